// File: rtl/mem_except_seq.sv
// MEM-stage exception/ERET sequencer: prioritises exception events, updates CP0 state,
// flushes the pipeline for a fixed number of cycles, then issues a handshaked fetch redirect.
module mem_except_seq #(
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [8:0]  mem_except,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic [31:0] mem_badvaddr,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [31:0] cp0_epc,
    output logic [31:0] cp0_badvaddr,
    output logic [4:0]  cp0_exccode,
    output logic        cp0_bd,
    output logic        cp0_exl
);

    typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_t;

    localparam logic [3:0] CntLast = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        bd_q, bd_d;
    logic        exl_q, exl_d;

    logic        eff_int, exc_any, trigger;
    logic [4:0]  code;

    // Interrupts are masked while already inside a handler.
    assign eff_int = mem_except[1] & ~exl_q;
    assign exc_any = eff_int | (|mem_except[8:2]);
    assign trigger = mem_valid & (exc_any | mem_except[0]);

    always_comb begin
        code = 5'd0;
        if (eff_int)            code = 5'd0;
        else if (mem_except[2]) code = 5'd4;
        else if (mem_except[3]) code = 5'd10;
        else if (mem_except[4]) code = 5'd12;
        else if (mem_except[5]) code = 5'd8;
        else if (mem_except[6]) code = 5'd9;
        else if (mem_except[7]) code = 5'd4;
        else if (mem_except[8]) code = 5'd5;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        exccode_d  = exccode_q;
        bd_d       = bd_q;
        exl_d      = exl_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StFlush;
                    cnt_d   = 4'd0;
                    if (exc_any) begin
                        exccode_d = code;
                        if (!exl_q) begin
                            epc_d = mem_bd ? (mem_pc - 32'd4) : mem_pc;
                            bd_d  = mem_bd;
                        end
                        exl_d    = 1'b1;
                        target_d = EXC_VECTOR;
                        if (!eff_int && mem_except[2]) begin
                            badvaddr_d = mem_pc;
                        end else if (!eff_int && (mem_except[7:3] == 5'b0)
                                     && (mem_except[7] | mem_except[8])) begin
                            badvaddr_d = mem_badvaddr;
                        end else if (!eff_int && (mem_except[6:3] == 4'b0)
                                     && mem_except[7]) begin
                            badvaddr_d = mem_badvaddr;
                        end
                    end else begin
                        exl_d    = 1'b0;
                        target_d = epc_q;
                    end
                end
            end
            StFlush: begin
                if (cnt_q == CntLast) begin
                    state_d = StRedirect;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRedirect: begin
                if (redirect_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            target_q   <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            exccode_q  <= 5'd0;
            bd_q       <= 1'b0;
            exl_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            exccode_q  <= exccode_d;
            bd_q       <= bd_d;
            exl_q      <= exl_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign flush          = busy;
    assign redirect_valid = (state_q == StRedirect);
    assign redirect_pc    = redirect_valid ? target_q : 32'd0;
    assign cp0_epc        = epc_q;
    assign cp0_badvaddr   = badvaddr_q;
    assign cp0_exccode    = exccode_q;
    assign cp0_bd         = bd_q;
    assign cp0_exl        = exl_q;

endmodule

// File: tb/tb_mem_except_seq.sv
// Directed bench for mem_except_seq with hand-computed expected values.
module tb_mem_except_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [8:0]  mem_except;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [31:0] mem_badvaddr;
    logic        redirect_ready;
    logic        flush, redirect_valid, busy, cp0_bd, cp0_exl;
    logic [31:0] redirect_pc, cp0_epc, cp0_badvaddr;
    logic [4:0]  cp0_exccode;

    int nvec = 0;
    int nerr = 0;

    mem_except_seq #(
        .EXC_VECTOR  (32'hbfc0_0380),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_valid     (mem_valid),
        .mem_except    (mem_except),
        .mem_pc        (mem_pc),
        .mem_bd        (mem_bd),
        .mem_badvaddr  (mem_badvaddr),
        .redirect_ready(redirect_ready),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .busy          (busy),
        .cp0_epc       (cp0_epc),
        .cp0_badvaddr  (cp0_badvaddr),
        .cp0_exccode   (cp0_exccode),
        .cp0_bd        (cp0_bd),
        .cp0_exl       (cp0_exl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trig(input logic [8:0] exc, input logic [31:0] pc, input logic bd,
                        input logic [31:0] bva);
        mem_valid    = 1'b1;
        mem_except   = exc;
        mem_pc       = pc;
        mem_bd       = bd;
        mem_badvaddr = bva;
        step();
        mem_valid  = 1'b0;
        mem_except = 9'h000;
    endtask

    // Two flush cycles after the trigger edge, then one edge into REDIRECT.
    task automatic to_redirect(input string tag, input logic [31:0] tgt);
        check({tag, ".flush1"}, {31'd0, flush}, 32'd1);
        check({tag, ".rv1"}, {31'd0, redirect_valid}, 32'd0);
        step();
        check({tag, ".flush2"}, {31'd0, flush}, 32'd1);
        check({tag, ".rv2"}, {31'd0, redirect_valid}, 32'd0);
        step();
        check({tag, ".rv"}, {31'd0, redirect_valid}, 32'd1);
        check({tag, ".rpc"}, redirect_pc, tgt);
        check({tag, ".flush3"}, {31'd0, flush}, 32'd1);
    endtask

    task automatic accept(input string tag);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".idle_rv"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, ".idle_flush"}, {31'd0, flush}, 32'd0);
        check({tag, ".idle_rpc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_except = 9'h000; mem_pc = 32'd0;
        mem_bd = 1'b0; mem_badvaddr = 32'd0; redirect_ready = 1'b0;
        #12;
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.epc", cp0_epc, 32'd0);
        check("rst.exl", {31'd0, cp0_exl}, 32'd0);
        resetn = 1'b1;
        step();

        // mem_valid low: no trigger
        mem_except = 9'h020;
        step();
        mem_except = 9'h000;
        check("novalid.busy", {31'd0, busy}, 32'd0);

        // Syscall
        trig(9'h020, 32'h8000_1000, 1'b0, 32'd0);
        check("sys.epc", cp0_epc, 32'h8000_1000);
        check("sys.code", {27'd0, cp0_exccode}, 32'd8);
        check("sys.exl", {31'd0, cp0_exl}, 32'd1);
        check("sys.bd", {31'd0, cp0_bd}, 32'd0);
        to_redirect("sys", 32'hbfc0_0380);
        accept("sys");

        // ERET back to EPC
        trig(9'h001, 32'hbfc0_0400, 1'b0, 32'd0);
        check("eret.exl", {31'd0, cp0_exl}, 32'd0);
        check("eret.code", {27'd0, cp0_exccode}, 32'd8);
        to_redirect("eret", 32'h8000_1000);
        accept("eret");

        // RI+Ov in delay slot: RI wins, EPC backs up to the branch
        trig(9'h018, 32'h8000_2004, 1'b1, 32'd0);
        check("ds.code", {27'd0, cp0_exccode}, 32'd10);
        check("ds.epc", cp0_epc, 32'h8000_2000);
        check("ds.bd", {31'd0, cp0_bd}, 32'd1);
        to_redirect("ds", 32'hbfc0_0380);
        accept("ds");

        // Interrupt masked by EXL
        trig(9'h002, 32'h8000_9000, 1'b0, 32'd0);
        check("mint.busy", {31'd0, busy}, 32'd0);
        check("mint.code", {27'd0, cp0_exccode}, 32'd10);
        check("mint.epc", cp0_epc, 32'h8000_2000);

        trig(9'h001, 32'h8000_9000, 1'b0, 32'd0);
        to_redirect("eret2", 32'h8000_2000);
        accept("eret2");

        // Interrupt taken once EXL is clear; it also beats AdES
        trig(9'h102, 32'h8000_3000, 1'b0, 32'h5555_5555);
        check("int.code", {27'd0, cp0_exccode}, 32'd0);
        check("int.epc", cp0_epc, 32'h8000_3000);
        check("int.bd", {31'd0, cp0_bd}, 32'd0);
        check("int.bva", cp0_badvaddr, 32'd0);
        to_redirect("int", 32'hbfc0_0380);
        accept("int");

        // AdES while EXL=1: EPC/BD held, BadVAddr loaded, backpressure
        trig(9'h100, 32'h8000_4000, 1'b1, 32'h1234_5679);
        check("ades.bva", cp0_badvaddr, 32'h1234_5679);
        check("ades.code", {27'd0, cp0_exccode}, 32'd5);
        check("ades.epc", cp0_epc, 32'h8000_3000);
        check("ades.bd", {31'd0, cp0_bd}, 32'd0);
        to_redirect("ades", 32'hbfc0_0380);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.rv", {31'd0, redirect_valid}, 32'd1);
            check("bp.rpc", redirect_pc, 32'hbfc0_0380);
            check("bp.flush", {31'd0, flush}, 32'd1);
        end
        accept("ades");

        // AdEL-fetch on the first IDLE cycle: BadVAddr takes the PC
        trig(9'h084, 32'h8000_5001, 1'b0, 32'h7777_7777);
        check("adelf.code", {27'd0, cp0_exccode}, 32'd4);
        check("adelf.bva", cp0_badvaddr, 32'h8000_5001);
        check("adelf.busy", {31'd0, busy}, 32'd1);
        to_redirect("adelf", 32'hbfc0_0380);
        accept("adelf");

        // AdEL-load: BadVAddr from data address
        trig(9'h080, 32'h8000_6000, 1'b0, 32'hdead_beef);
        check("adell.code", {27'd0, cp0_exccode}, 32'd4);
        check("adell.bva", cp0_badvaddr, 32'hdead_beef);

        // Async reset mid-FLUSH
        #2;
        resetn = 1'b0;
        #1;
        check("mrst.flush", {31'd0, flush}, 32'd0);
        check("mrst.busy", {31'd0, busy}, 32'd0);
        check("mrst.exl", {31'd0, cp0_exl}, 32'd0);
        check("mrst.bva", cp0_badvaddr, 32'd0);
        check("mrst.code", {27'd0, cp0_exccode}, 32'd0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post.rv", {31'd0, redirect_valid}, 32'd0);
            check("post.busy", {31'd0, busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
